// File: rtl/switch_bounce_gen.sv
// Switch emulator: clean level in, LFSR-timed bouncing sw out.
// Define SWITCH_BOUNCE_GEN_FIXED_EN for a fixed glitch width of 2^(GW-1).
module switch_bounce_gen #(
  parameter int          BOUNCE_CYC = 1000,
  parameter int          GW         = 4,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic sw,
  output logic busy,
  output logic done_tick,
  output logic settled
);

  localparam logic [15:0] SEED_EFF =
    (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam int CW = 20;
  localparam logic [CW-1:0] WIN_LOAD =
    CW'(BOUNCE_CYC - 1);

  typedef enum logic {
    IDLE,
    BOUNCE
  } state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic          fb;
  logic [CW-1:0] win_cnt;
  logic [GW-1:0] gl_cnt;
  logic [GW-1:0] w_m1;
  logic          target;

  assign fb = lfsr[15] ^ lfsr[13]
            ^ lfsr[12] ^ lfsr[10];

`ifdef SWITCH_BOUNCE_GEN_FIXED_EN
  assign w_m1 = GW'((2 ** (GW - 1)) - 1);
`else
  assign w_m1 = lfsr[GW-1:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lfsr      <= SEED_EFF;
      win_cnt   <= '0;
      gl_cnt    <= '0;
      target    <= 1'b0;
      sw        <= 1'b0;
      busy      <= 1'b0;
      done_tick <= 1'b0;
      settled   <= 1'b0;
    end else begin
      lfsr      <= {lfsr[14:0], fb};
      done_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          sw <= settled;
          if (level_in != settled) begin
            target  <= level_in;
            sw      <= level_in;
            win_cnt <= WIN_LOAD;
            gl_cnt  <= w_m1;
            busy    <= 1'b1;
            state   <= BOUNCE;
          end
        end
        BOUNCE: begin
          if (win_cnt == '0) begin
            sw        <= target;
            settled   <= target;
            busy      <= 1'b0;
            done_tick <= 1'b1;
            state     <= IDLE;
          end else begin
            win_cnt <= win_cnt - 1'b1;
            if (gl_cnt == '0) begin
              sw     <= ~sw;
              gl_cnt <= w_m1;
            end else begin
              gl_cnt <= gl_cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Randomized bench for switch_bounce_gen against an
// event-time reference model.
module tb_switch_bounce_gen;

  localparam int          B    = 100;
  localparam int          GW   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic level_in = 1'b0;
  logic sw, busy, done_tick, settled;

  int checks = 0;
  int failures = 0;

  switch_bounce_gen #(
    .BOUNCE_CYC(B),
    .GW(GW),
    .SEED(SEED)
  ) dut (
    .clk(clk),
    .reset(reset),
    .level_in(level_in),
    .sw(sw),
    .busy(busy),
    .done_tick(done_tick),
    .settled(settled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // Reference model: bounce described by absolute
  // edge times of the window end and the next toggle.
  logic [15:0] m_lfsr;
  bit    m_sw, m_busy, m_done, m_set, m_tgt;
  longint m_cyc, end_e, next_t;

  function automatic logic [15:0] lfsr_adv(
      input logic [15:0] v);
    int taps[4] = '{16, 14, 13, 11};
    logic f = 1'b0;
    foreach (taps[i]) f ^= v[taps[i]-1];
    return {v[14:0], f};
  endfunction

  function automatic longint width(
      input logic [15:0] v);
`ifdef SWITCH_BOUNCE_GEN_FIXED_EN
    return longint'(2 ** (GW - 1));
`else
    return longint'(v % (2 ** GW)) + 1;
`endif
  endfunction

  task automatic model_reset();
    m_lfsr = SEED;
    m_sw = 0; m_busy = 0;
    m_done = 0; m_set = 0; m_tgt = 0;
  endtask

  task automatic model_edge(input bit lvl);
    logic [15:0] cur = m_lfsr;
    m_done = 0;
    if (!m_busy) begin
      m_sw = m_set;
      if (lvl != m_set) begin
        m_tgt = lvl;
        m_sw = lvl;
        m_busy = 1;
        end_e = m_cyc + B;
        next_t = m_cyc + width(cur);
      end
    end else if (m_cyc == end_e) begin
      m_sw = m_tgt;
      m_set = m_tgt;
      m_busy = 0;
      m_done = 1;
    end else if (m_cyc == next_t) begin
      m_sw = ~m_sw;
      next_t = m_cyc + width(cur);
    end
    m_lfsr = lfsr_adv(cur);
    m_cyc++;
  endtask

  task automatic compare_all();
    chk("sw", 32'(sw), 32'(m_sw));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done_tick", 32'(done_tick), 32'(m_done));
    chk("settled", 32'(settled), 32'(m_set));
  endtask

  // DUT-side observation state
  int ecnt = 0, entry = 0, last = 0;
  int n_done = 0, bcnt = 0;
  bit was_busy = 0, prev_sw = 0;
  int tq[$];
  int qa[$];

  task automatic step();
    int sp;
    @(posedge clk);
    if (reset) model_edge(level_in);
    #1;
    ecnt++;
    compare_all();
    if (done_tick === 1'b1) n_done++;
    if (busy === 1'b1) bcnt++;
    if (busy === 1'b1 && !was_busy) begin
      entry = ecnt;
      last = ecnt;
      tq.delete();
    end else if (busy === 1'b1 && was_busy &&
                 sw !== prev_sw) begin
      sp = ecnt - last;
      chk("spacing",
          32'(sp >= 1 && sp <= 2 ** GW), 32'd1);
      tq.push_back(ecnt - entry);
      last = ecnt;
    end
    was_busy = (busy === 1'b1);
    prev_sw = (sw === 1'b1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    steps(n);
    reset = 1'b1;
  endtask

  initial begin
    m_cyc = 0;
    level_in = 1'b1;
    #1;
    do_reset(2);

    // same seed, same toggle schedule
    steps(B + 20);
    chk("run_a_settled", 32'(settled), 32'd1);
    qa = tq;
    chk("run_a_toggles", 32'(qa.size() > 0), 32'd1);
    do_reset(2);
    steps(B + 20);
    chk("repeat_len", 32'(tq.size()),
        32'(qa.size()));
    foreach (qa[i])
      if (i < tq.size())
        chk("repeat_toggle", 32'(tq[i]), 32'(qa[i]));

    // short pulse replays as two full bounces
    level_in = 1'b0;
    steps(B + 20);
    n_done = 0;
    level_in = 1'b1;
    steps(30);
    level_in = 1'b0;
    steps(2 * B + 40);
    chk("pulse_dones", 32'(n_done), 32'd2);
    chk("pulse_settled", 32'(settled), 32'd0);

    // reset in the middle of a window
    n_done = 0;
    level_in = 1'b1;
    steps(41);
    chk("mid_busy", 32'(busy), 32'd1);
    do_reset(2);
    chk("mid_no_done", 32'(n_done), 32'd0);
    bcnt = 0;
    steps(B + 10);
    chk("mid_busy_len", 32'(bcnt), 32'(B));
    chk("mid_dones", 32'(n_done), 32'd1);
    chk("mid_settled", 32'(settled), 32'd1);

    // random level changes and occasional resets
    for (int k = 0; k < 40; k++) begin
      level_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        steps($urandom_range(1, 60));
        do_reset($urandom_range(1, 3));
      end
      steps($urandom_range(1, 250));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_bounce_gen.md
# switch_bounce_gen

- Synthesizable mechanical-switch emulator: the driving end of the debouncer interface.
- Takes a clean requested level and produces a bouncing `sw` waveform: pseudo-random glitches for a fixed window, then settles to the requested level.
- Drives the `sw` input of the debouncer in on-chip self-test and bench setups, so debounce behaviour can be exercised without a physical switch.

## Interface
Parameters:
- `BOUNCE_CYC`, 1000: length of the bounce window in clocks; legal range 2..2^20-1.
- `GW`, 4: glitch-width field width; glitch widths span 1..2^GW clocks.
- `SEED`, 16'hACE1: LFSR reset value; 0 is replaced by 16'hACE1.

Ports:
- `clk` input 1: single clock; all state is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `level_in` input 1: clean requested switch level, sampled every clock.
- `sw` output 1: bouncing switch output, registered.
- `busy` output 1: high while a bounce window is in progress.
- `done_tick` output 1: one-clock pulse when `sw` has settled.
- `settled` output 1: last settled level.

## Operation
- State machine with two states, IDLE and BOUNCE.
- Reset (`reset`=0, asynchronous):
  - state IDLE, `sw`=0, `settled`=0, `busy`=0, `done_tick`=0.
  - LFSR=SEED, window counter=0, glitch counter=0.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. It advances every clock out of reset, in both states.
- Glitch width W:
  - W = LFSR[GW-1:0]+1, sampled at each load.
  - With the fixed-width macro defined, W is fixed (see Configuration).
- IDLE:
  - `sw` holds `settled`.
  - If `level_in` != `settled`: latch target=`level_in`, set `sw`<=target, window counter <= BOUNCE_CYC-1, glitch counter <= W-1, `busy`<=1, go to BOUNCE.
- BOUNCE: the window check has priority.
  - Window counter = 0:
    - `sw`<=target, `settled`<=target, `busy`<=0, `done_tick`<=1, go to IDLE.
    - No glitch toggle in this cycle.
  - Otherwise the window counter decrements, then:
    - glitch counter = 0: `sw` toggles and the glitch counter reloads W-1;
    - glitch counter != 0: the glitch counter decrements.
- `level_in` is ignored in BOUNCE.
  - The latched target always completes.
  - If `level_in` differs from the new `settled` on return to IDLE, the next bounce starts on the following edge.
  - A level pulse shorter than the window is therefore replayed as two full bounces, first to the pulse level and then back.
- `done_tick` is high for exactly one clock and is cleared on the next edge.

## Timing
- Change detected at edge E0:
  - `sw`=target after E0; `busy` is high after E0.
  - `busy` is high for exactly BOUNCE_CYC clocks (E0..E(BOUNCE_CYC-1)) and falls after edge E(BOUNCE_CYC).
  - `done_tick` is high after edge E(BOUNCE_CYC) and low after the next edge.
  - `settled` updates together with `done_tick`.
- Toggles occur at edges E0+W1, E0+W1+W2, …, strictly before E(BOUNCE_CYC).
- Minimum spacing between `sw` edges is 1 clock; maximum spacing during bounce is 2^GW clocks.
- Back-to-back bounces: after `done_tick`, the earliest next bounce entry is the edge following E(BOUNCE_CYC), i.e. IDLE lasts at least 1 clock.
- Reset asserted mid-bounce:
  - All outputs go to their reset values immediately (asynchronously), and the LFSR reloads SEED.
  - No `done_tick` is issued.
  - After release, a `level_in`=1 restarts a full window.

## Configuration
- Macro `SWITCH_BOUNCE_GEN_FIXED_EN`.
- Defined: W = 2^(GW-1) constant (8 for GW=4). The bounce waveform is fully deterministic; the LFSR still runs but is unused.
- Undefined: W is drawn from the LFSR as above.

## Test plan
- Reset: hold `reset`=0 for 2 clocks with `level_in`=1 -> `sw`=0, `busy`=0, `done_tick`=0, `settled`=0 throughout.
- Fixed mode, BOUNCE_CYC=100, GW=4, `level_in` 0->1:
  - `sw`=1 at E0, followed by exactly 12 toggles, spaced 8 clocks apart at E8..E96;
  - `busy` high 100 clocks; single `done_tick` after E100; `sw`=1 and `settled`=1 afterwards.
- LFSR mode, BOUNCE_CYC=1000:
  - every `sw` toggle spacing is between 1 and 16 clocks; `sw`=1 after E1000;
  - the same SEED reproduces an identical toggle sequence across two runs.
- Pulse on `level_in` (0->1->0 within 50 clocks, BOUNCE_CYC=100):
  - first window completes to 1 with a `done_tick`;
  - the next bounce starts 1 clock later and settles to 0;
  - exactly 2 `done_tick` pulses in total.
- Reset mid-bounce at E40:
  - `sw`=0 and `busy`=0 immediately; no `done_tick`;
  - after release with `level_in`=1, a new 100-clock window runs.
- Connect to the debouncer, switch window 2^16 clocks, bounce window 2^15 clocks: debouncer `db` goes to 1 exactly once, with a single `m_tick`, and stays 1.
